// File: rtl/heatmap_row_reader.sv
// heatmap_row_reader
// Read-side consumer of the colour RAM. Each step it releases the writer
// with a one-cycle comp_allow pulse, waits for done_write_sig, then reads
// every node colour and paints it as a BLOCK_W x BLOCK_H rectangle into the
// pixel buffer. Successive steps land on successive block-rows, producing a
// scrolling waterfall heat map.
// Optional feature macro: HEATMAP_GRIDLINES_EN (black grid on the first
// column and first line of every block).
module heatmap_row_reader #(
  parameter int N_NODES  = 64,
  parameter int BLOCK_W  = 10,
  parameter int BLOCK_H  = 4,
  parameter int N_ROWS   = 120,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0,
  parameter int RAM_LAT  = 2
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       done_write_sig,
  output logic       comp_allow,
  output logic [7:0] read_addr,
  input  logic [7:0] read_data,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [7:0] pixel_color,
  output logic       pixel_we,
  input  logic       pixel_ack,
  output logic [7:0] row_index,
  output logic       busy
);

  localparam int SX_W = $clog2(BLOCK_W + 1);
  localparam int SY_W = $clog2(BLOCK_H + 1);
  localparam int WT_W = $clog2(RAM_LAT + 2);

  localparam logic [SX_W-1:0] SX_LAST   = SX_W'(BLOCK_W - 1);
  localparam logic [SY_W-1:0] SY_LAST   = SY_W'(BLOCK_H - 1);
  localparam logic [7:0]      NODE_LAST = 8'(N_NODES - 1);
  localparam logic [7:0]      ROW_LAST  = 8'(N_ROWS - 1);
  localparam logic [WT_W-1:0] WAIT_INIT = WT_W'(RAM_LAT);

`ifdef HEATMAP_GRIDLINES_EN
  localparam logic GRID_EN = 1'b1;
`else
  localparam logic GRID_EN = 1'b0;
`endif

  localparam logic [2:0] ST_ALLOW     = 3'd0;
  localparam logic [2:0] ST_WAIT_DONE = 3'd1;
  localparam logic [2:0] ST_RD_ADDR   = 3'd2;
  localparam logic [2:0] ST_RD_WAIT   = 3'd3;
  localparam logic [2:0] ST_PIX       = 3'd4;
  localparam logic [2:0] ST_NEXT      = 3'd5;
  localparam logic [2:0] ST_ROW_ADV   = 3'd6;

  logic [2:0]      state_r;
  logic [7:0]      node_r;
  logic [SX_W-1:0] sub_x_r;
  logic [SY_W-1:0] sub_y_r;
  logic [WT_W-1:0] wait_r;
  logic [7:0]      colour_r;
  logic            done_pending_r;

  logic [SX_W-1:0] nx_sub_x_s;
  logic [SY_W-1:0] nx_sub_y_s;
  logic            last_pix_s;

  // Screen x of a pixel inside the block of a given node.
  function automatic logic [9:0] calc_x(input logic [7:0] node, input logic [SX_W-1:0] sx);
    calc_x = 10'(X_ORIGIN) + 10'(node) * 10'(BLOCK_W) + 10'(sx);
  endfunction

  // Screen y of a pixel line inside the current block-row.
  function automatic logic [9:0] calc_y(input logic [7:0] row, input logic [SY_W-1:0] sy);
    calc_y = 10'(Y_ORIGIN) + 10'(row) * 10'(BLOCK_H) + 10'(sy);
  endfunction

  // Colour of a pixel: grid pixels go black only when the grid feature is built in.
  function automatic logic [7:0] pick_color(input logic [7:0] c, input logic on_grid);
    if (GRID_EN && on_grid) begin
      pick_color = 8'h00;
    end else begin
      pick_color = c;
    end
  endfunction

  // Raster successor of the current pixel within the block.
  always_comb begin
    last_pix_s = (sub_x_r == SX_LAST) && (sub_y_r == SY_LAST);
    if (sub_x_r == SX_LAST) begin
      nx_sub_x_s = '0;
      nx_sub_y_s = sub_y_r + SY_W'(1);
    end else begin
      nx_sub_x_s = sub_x_r + SX_W'(1);
      nx_sub_y_s = sub_y_r;
    end
  end

  // Step sequencer: writer release, RAM read, block painting and row advance.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      state_r        <= ST_ALLOW;
      node_r         <= 8'd0;
      sub_x_r        <= '0;
      sub_y_r        <= '0;
      wait_r         <= '0;
      colour_r       <= 8'h00;
      done_pending_r <= 1'b0;
      comp_allow     <= 1'b0;
      read_addr      <= 8'd0;
      pixel_x        <= 10'(X_ORIGIN);
      pixel_y        <= 10'(Y_ORIGIN);
      pixel_color    <= 8'h00;
      pixel_we       <= 1'b0;
      row_index      <= 8'd0;
      busy           <= 1'b1;
    end else begin
      comp_allow <= 1'b0;
      // The writer's done pulse may arrive at any time once it is released.
      if (done_write_sig && (state_r != ST_ALLOW)) begin
        done_pending_r <= 1'b1;
      end
      case (state_r)
        ST_ALLOW: begin
          comp_allow <= 1'b1;
          busy       <= 1'b0;
          state_r    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done_pending_r) begin
            done_pending_r <= 1'b0;
            node_r         <= 8'd0;
            busy           <= 1'b1;
            state_r        <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          read_addr <= node_r;
          wait_r    <= WAIT_INIT;
          state_r   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (wait_r == '0) begin
            colour_r    <= read_data;
            sub_x_r     <= '0;
            sub_y_r     <= '0;
            pixel_we    <= 1'b1;
            pixel_x     <= calc_x(node_r, '0);
            pixel_y     <= calc_y(row_index, '0);
            pixel_color <= pick_color(read_data, 1'b1);
            state_r     <= ST_PIX;
          end else begin
            wait_r <= wait_r - WT_W'(1);
          end
        end
        ST_PIX: begin
          if (pixel_ack) begin
            if (last_pix_s) begin
              pixel_we <= 1'b0;
              state_r  <= ST_NEXT;
            end else begin
              sub_x_r     <= nx_sub_x_s;
              sub_y_r     <= nx_sub_y_s;
              pixel_x     <= calc_x(node_r, nx_sub_x_s);
              pixel_y     <= calc_y(row_index, nx_sub_y_s);
              pixel_color <= pick_color(colour_r, (nx_sub_x_s == '0) || (nx_sub_y_s == '0));
            end
          end
        end
        ST_NEXT: begin
          if (node_r == NODE_LAST) begin
            state_r <= ST_ROW_ADV;
          end else begin
            node_r  <= node_r + 8'd1;
            state_r <= ST_RD_ADDR;
          end
        end
        ST_ROW_ADV: begin
          row_index <= (row_index == ROW_LAST) ? 8'd0 : row_index + 8'd1;
          state_r   <= ST_ALLOW;
        end
        default: begin
          pixel_we <= 1'b0;
          busy     <= 1'b1;
          state_r  <= ST_ALLOW;
        end
      endcase
    end
  end

endmodule
